// File: rtl/controle_multiciclo_pkg.sv
// -----------------------------------------------------------------------------
// controle_multiciclo_pkg
// Shared definitions for the multicycle control FSM. These are used by the
// controller, its wait counter, and any display/debug logic.
//   - estado_t          : 4-bit state codes seen on the estado port
//   - enables_t         : phase-enable bundle driven to the datapath
//   - WAIT_W            : width of the EXW/WBW settle counter
//   - decode_enables()  : Moore decode of a state into its phase enables
//   - wait_load()       : counter preload for an N-cycle wait (N-1, or 0)
// -----------------------------------------------------------------------------
package controle_multiciclo_pkg;

    localparam int WAIT_W = $clog2(16);

    typedef enum logic [3:0] {
        ST_IF    = 4'b0000,
        ST_ID    = 4'b0001,
        ST_EX    = 4'b0010,
        ST_MEM   = 4'b0011,
        ST_WB    = 4'b0100,
        ST_EXW   = 4'b0101,
        ST_WBW   = 4'b0110,
        ST_PCUP  = 4'b1000,
        ST_HALT  = 4'b1001,
        ST_STEPW = 4'b1010
    } estado_t;

    typedef struct packed {
        logic en_if;
        logic en_id;
        logic en_ex;
        logic en_mem;
        logic en_wb;
        logic en_pc;
    } enables_t;

    // At most one phase enable is high. The wait, halt and step states
    // drive none of them.
    function automatic enables_t decode_enables(input estado_t s);
        enables_t e;
        e = '{default: 1'b0};
        case (s)
            ST_IF:   e.en_if  = 1'b1;
            ST_ID:   e.en_id  = 1'b1;
            ST_EX:   e.en_ex  = 1'b1;
            ST_MEM:  e.en_mem = 1'b1;
            ST_WB:   e.en_wb  = 1'b1;
            ST_PCUP: e.en_pc  = 1'b1;
            default: e = '{default: 1'b0};
        endcase
        return e;
    endfunction

    // The counter is loaded on entry to a wait state, and the wait state
    // exits when the counter reads zero. Loading N-1 therefore gives N
    // cycles in the wait state.
    function automatic logic [WAIT_W-1:0] wait_load(input int n);
        logic [WAIT_W-1:0] v;
        if (n > 0) begin
            v = WAIT_W'(n - 1);
        end else begin
            v = {WAIT_W{1'b0}};
        end
        return v;
    endfunction

endpackage

// File: rtl/controle_multiciclo_contador_espera.sv
// -----------------------------------------------------------------------------
// contador_espera
// Loadable down-counter with a zero flag. The controller uses it for both
// the EX settle wait (EXW) and the WB settle wait (WBW).
//   clk      in   clock
//   rst      in   synchronous active-high reset (counter -> 0)
//   load_i   in   load value_i on this edge (has priority over dec_i)
//   value_i  in   preload value
//   dec_i    in   decrement on this edge; the counter stops at zero
//   zero_o   out  counter currently reads zero
// -----------------------------------------------------------------------------
module contador_espera
    import controle_multiciclo_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              load_i,
    input  logic [WAIT_W-1:0] value_i,
    input  logic              dec_i,
    output logic              zero_o
);

    logic [WAIT_W-1:0] cnt_q;

    // Counter register: reset, then load, then decrement, otherwise hold.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q <= {WAIT_W{1'b0}};
        end else if (load_i) begin
            cnt_q <= value_i;
        end else if (dec_i && (cnt_q != {WAIT_W{1'b0}})) begin
            cnt_q <= cnt_q - WAIT_W'(1);
        end else begin
            cnt_q <= cnt_q;
        end
    end

    assign zero_o = (cnt_q == {WAIT_W{1'b0}});

endmodule

// File: rtl/controle_multiciclo.sv
// -----------------------------------------------------------------------------
// controle_multiciclo
// Multicycle control FSM for the single-issue RISC-V datapath. It steps the
// datapath through IF/ID/EX/MEM/WB/PCUP one phase at a time. The controller
// also provides:
//   - optional EX and WB settle waits,
//   - a MEM stall handshake,
//   - single-step mode,
//   - cycle and retired-instruction counters.
// Parameters:
//   EX_WAIT (0..15)  settle cycles between EX and MEM
//   WB_WAIT (0..15)  settle cycles between WB and PCUP
//   CNT_W            width of the cycle and instruction counters
// Ports:
//   clk, rst                 clock and synchronous active-high reset
//   instr_zero               fetched instruction is zero (halt marker), used in ID
//   mem_busy                 memory not ready, sampled only in MEM
//   step_mode, step          single-step enable and advance pulse (used in STEPW)
//   estado                   current state code
//   en_if..en_pc             registered Moore phase enables
//   final_o                  sticky "execution finished" flag
//   cycle_count              cycles since reset, excluding HALT (saturating)
//   instr_count              retired instructions (wrapping)
// "final" is a reserved word, so the finished flag is named final_o.
// -----------------------------------------------------------------------------
module controle_multiciclo
    import controle_multiciclo_pkg::*;
#(
    parameter int EX_WAIT = 2,
    parameter int WB_WAIT = 3,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             instr_zero,
    input  logic             mem_busy,
    input  logic             step_mode,
    input  logic             step,
    output logic [3:0]       estado,
    output logic             en_if,
    output logic             en_id,
    output logic             en_ex,
    output logic             en_mem,
    output logic             en_wb,
    output logic             en_pc,
    output logic             final_o,
    output logic [CNT_W-1:0] cycle_count,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [WAIT_W-1:0] EX_LOAD = wait_load(EX_WAIT);
    localparam logic [WAIT_W-1:0] WB_LOAD = wait_load(WB_WAIT);

    estado_t           estado_q, estado_d;
    enables_t          en_q;
    logic              final_q;
    logic [CNT_W-1:0]  cycle_q;
    logic [CNT_W-1:0]  instr_q;

    logic              cnt_load_s;
    logic [WAIT_W-1:0] cnt_value_s;
    logic              cnt_dec_s;
    logic              cnt_zero_s;

    contador_espera u_espera (
        .clk     (clk),
        .rst     (rst),
        .load_i  (cnt_load_s),
        .value_i (cnt_value_s),
        .dec_i   (cnt_dec_s),
        .zero_o  (cnt_zero_s)
    );

    // Next-state logic. The wait counter is preloaded on the edge that
    // enters EXW or WBW.
    always_comb begin
        estado_d    = ST_IF;
        cnt_load_s  = 1'b0;
        cnt_value_s = {WAIT_W{1'b0}};
        cnt_dec_s   = 1'b0;
        case (estado_q)
            ST_IF: estado_d = ST_ID;
            ST_ID: begin
                if (instr_zero) begin
                    estado_d = ST_HALT;
                end else begin
                    estado_d = ST_EX;
                end
            end
            ST_EX: begin
                if (EX_WAIT > 0) begin
                    estado_d    = ST_EXW;
                    cnt_load_s  = 1'b1;
                    cnt_value_s = EX_LOAD;
                end else begin
                    estado_d = ST_MEM;
                end
            end
            ST_EXW: begin
                if (cnt_zero_s) begin
                    estado_d = ST_MEM;
                end else begin
                    estado_d  = ST_EXW;
                    cnt_dec_s = 1'b1;
                end
            end
            ST_MEM: begin
                if (mem_busy) begin
                    estado_d = ST_MEM;
                end else begin
                    estado_d = ST_WB;
                end
            end
            ST_WB: begin
                if (WB_WAIT > 0) begin
                    estado_d    = ST_WBW;
                    cnt_load_s  = 1'b1;
                    cnt_value_s = WB_LOAD;
                end else begin
                    estado_d = ST_PCUP;
                end
            end
            ST_WBW: begin
                if (cnt_zero_s) begin
                    estado_d = ST_PCUP;
                end else begin
                    estado_d  = ST_WBW;
                    cnt_dec_s = 1'b1;
                end
            end
            ST_PCUP: begin
                if (step_mode) begin
                    estado_d = ST_STEPW;
                end else begin
                    estado_d = ST_IF;
                end
            end
            ST_STEPW: begin
                if (step) begin
                    estado_d = ST_IF;
                end else begin
                    estado_d = ST_STEPW;
                end
            end
            ST_HALT: estado_d = ST_HALT;
            default: estado_d = ST_IF;
        endcase
    end

    // State, registered enables, finished flag and counters. The enables
    // are decoded from the next state, so they always match estado.
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= ST_IF;
            en_q     <= decode_enables(ST_IF);
            final_q  <= 1'b0;
            cycle_q  <= {CNT_W{1'b0}};
            instr_q  <= {CNT_W{1'b0}};
        end else begin
            estado_q <= estado_d;
            en_q     <= decode_enables(estado_d);
            final_q  <= final_q | (estado_d == ST_HALT);
            // HALT freezes the cycle count. The count also saturates at
            // all-ones instead of wrapping.
            if ((estado_q != ST_HALT) && (cycle_q != {CNT_W{1'b1}})) begin
                cycle_q <= cycle_q + CNT_W'(1);
            end else begin
                cycle_q <= cycle_q;
            end
            if (estado_q == ST_PCUP) begin
                instr_q <= instr_q + CNT_W'(1);
            end else begin
                instr_q <= instr_q;
            end
        end
    end

    assign estado      = estado_q;
    assign en_if       = en_q.en_if;
    assign en_id       = en_q.en_id;
    assign en_ex       = en_q.en_ex;
    assign en_mem      = en_q.en_mem;
    assign en_wb       = en_q.en_wb;
    assign en_pc       = en_q.en_pc;
    assign final_o     = final_q;
    assign cycle_count = cycle_q;
    assign instr_count = instr_q;

endmodule

// File: tb/tb_controle_multiciclo.sv
// -----------------------------------------------------------------------------
// tb_controle_multiciclo
// Directed bench for controle_multiciclo. It uses two instances:
//   - dut  : default waits (EX_WAIT=2, WB_WAIT=3)
//   - dutz : no settle waits (EX_WAIT=0, WB_WAIT=0)
// Inputs are driven and outputs sampled 1 ns after the rising edge.
// -----------------------------------------------------------------------------
module tb_controle_multiciclo;

    localparam logic [3:0] S_IF    = 4'b0000;
    localparam logic [3:0] S_ID    = 4'b0001;
    localparam logic [3:0] S_EX    = 4'b0010;
    localparam logic [3:0] S_MEM   = 4'b0011;
    localparam logic [3:0] S_WB    = 4'b0100;
    localparam logic [3:0] S_EXW   = 4'b0101;
    localparam logic [3:0] S_WBW   = 4'b0110;
    localparam logic [3:0] S_PCUP  = 4'b1000;
    localparam logic [3:0] S_HALT  = 4'b1001;
    localparam logic [3:0] S_STEPW = 4'b1010;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, instr_zero, mem_busy, step_mode, step;
    logic [3:0]  estado;
    logic        en_if, en_id, en_ex, en_mem, en_wb, en_pc, fin;
    logic [31:0] cyc, ins;

    logic        z_rst, z_instr_zero, z_mem_busy, z_step_mode, z_step;
    logic [3:0]  z_estado;
    logic        z_en_if, z_en_id, z_en_ex, z_en_mem, z_en_wb, z_en_pc, z_fin;
    logic [31:0] z_cyc, z_ins;

    controle_multiciclo #(.EX_WAIT(2), .WB_WAIT(3), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .instr_zero(instr_zero), .mem_busy(mem_busy),
        .step_mode(step_mode), .step(step), .estado(estado),
        .en_if(en_if), .en_id(en_id), .en_ex(en_ex), .en_mem(en_mem),
        .en_wb(en_wb), .en_pc(en_pc), .final_o(fin),
        .cycle_count(cyc), .instr_count(ins)
    );

    controle_multiciclo #(.EX_WAIT(0), .WB_WAIT(0), .CNT_W(32)) dutz (
        .clk(clk), .rst(z_rst), .instr_zero(z_instr_zero), .mem_busy(z_mem_busy),
        .step_mode(z_step_mode), .step(z_step), .estado(z_estado),
        .en_if(z_en_if), .en_id(z_en_id), .en_ex(z_en_ex), .en_mem(z_en_mem),
        .en_wb(z_en_wb), .en_pc(z_en_pc), .final_o(z_fin),
        .cycle_count(z_cyc), .instr_count(z_ins)
    );

    int n_chk  = 0;
    int n_pass = 0;

    typedef struct {
        logic        mb;    // mem_busy driven during this cycle
        logic [3:0]  st;    // expected estado this cycle
        logic [31:0] ic;    // expected instr_count this cycle
    } vec_t;

    vec_t tab [25];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Expected phase enables {if,id,ex,mem,wb,pc} for a state code.
    function automatic logic [5:0] en_exp(input logic [3:0] s);
        case (s)
            S_IF:    return 6'b100000;
            S_ID:    return 6'b010000;
            S_EX:    return 6'b001000;
            S_MEM:   return 6'b000100;
            S_WB:    return 6'b000010;
            S_PCUP:  return 6'b000001;
            default: return 6'b000000;
        endcase
    endfunction

    function automatic logic [5:0] en_act();
        return {en_if, en_id, en_ex, en_mem, en_wb, en_pc};
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        tick();
        rst = 1'b0;
    endtask

    initial begin
        logic [3:0] stp [17];
        logic [3:0] zst [8];
        logic       saw_mem_wb;

        rst = 1'b1; instr_zero = 1'b0; mem_busy = 1'b0; step_mode = 1'b0; step = 1'b0;
        z_rst = 1'b1; z_instr_zero = 1'b0; z_mem_busy = 1'b0; z_step_mode = 1'b0; z_step = 1'b0;

        // Two back-to-back instructions. The second one stalls in MEM for
        // two cycles.
        tab = '{
            '{1'b0, S_IF,   32'd0}, '{1'b0, S_ID,   32'd0}, '{1'b0, S_EX,   32'd0},
            '{1'b0, S_EXW,  32'd0}, '{1'b0, S_EXW,  32'd0}, '{1'b0, S_MEM,  32'd0},
            '{1'b0, S_WB,   32'd0}, '{1'b0, S_WBW,  32'd0}, '{1'b0, S_WBW,  32'd0},
            '{1'b0, S_WBW,  32'd0}, '{1'b0, S_PCUP, 32'd0},
            '{1'b0, S_IF,   32'd1}, '{1'b0, S_ID,   32'd1}, '{1'b0, S_EX,   32'd1},
            '{1'b0, S_EXW,  32'd1}, '{1'b0, S_EXW,  32'd1}, '{1'b1, S_MEM,  32'd1},
            '{1'b1, S_MEM,  32'd1}, '{1'b0, S_MEM,  32'd1}, '{1'b0, S_WB,   32'd1},
            '{1'b0, S_WBW,  32'd1}, '{1'b0, S_WBW,  32'd1}, '{1'b0, S_WBW,  32'd1},
            '{1'b0, S_PCUP, 32'd1}, '{1'b0, S_IF,   32'd2}
        };

        do_reset();
        for (int i = 0; i < 25; i++) begin
            mem_busy = tab[i].mb;
            chk($sformatf("seq%0d estado", i), {28'd0, estado}, {28'd0, tab[i].st});
            chk($sformatf("seq%0d enables", i), {26'd0, en_act()}, {26'd0, en_exp(tab[i].st)});
            chk($sformatf("seq%0d cycle_count", i), cyc, i);
            chk($sformatf("seq%0d instr_count", i), ins, tab[i].ic);
            chk($sformatf("seq%0d final", i), {31'd0, fin}, 32'd0);
            tick();
        end
        mem_busy = 1'b0;

        // A zero instruction halts the machine. final rises in the first
        // HALT cycle, and the cycle count freezes at 2.
        do_reset();
        instr_zero = 1'b1;
        chk("halt c1 estado", {28'd0, estado}, {28'd0, S_IF});
        tick();
        chk("halt c2 estado", {28'd0, estado}, {28'd0, S_ID});
        chk("halt c2 final", {31'd0, fin}, 32'd0);
        tick();
        saw_mem_wb = 1'b0;
        for (int c = 3; c < 9; c++) begin
            chk($sformatf("halt c%0d estado", c), {28'd0, estado}, {28'd0, S_HALT});
            chk($sformatf("halt c%0d final", c), {31'd0, fin}, 32'd1);
            chk($sformatf("halt c%0d cycle_count", c), cyc, 32'd2);
            saw_mem_wb = saw_mem_wb | en_mem | en_wb;
            tick();
        end
        chk("halt no mem/wb pulse", {31'd0, saw_mem_wb}, 32'd0);
        instr_zero = 1'b0;
        do_reset();
        chk("rst in halt estado", {28'd0, estado}, {28'd0, S_IF});
        chk("rst in halt final", {31'd0, fin}, 32'd0);
        chk("rst in halt cycle_count", cyc, 32'd0);

        // Single-step mode. A step pulse during EX must be ignored. After
        // PCUP the machine holds STEPW for 5 cycles, then a step pulse
        // returns it to IF.
        stp = '{S_IF, S_ID, S_EX, S_EXW, S_EXW, S_MEM, S_WB, S_WBW, S_WBW, S_WBW,
                S_PCUP, S_STEPW, S_STEPW, S_STEPW, S_STEPW, S_STEPW, S_IF};
        do_reset();
        step_mode = 1'b1;
        for (int c = 0; c < 17; c++) begin
            step = (c == 2) || (c == 15);
            chk($sformatf("step c%0d estado", c + 1), {28'd0, estado}, {28'd0, stp[c]});
            tick();
        end
        step = 1'b0;
        chk("step instr_count", ins, 32'd1);

        // Reset during a MEM stall. The counts are nonzero beforehand, so
        // this check shows that reset clears them.
        step_mode = 1'b0;
        mem_busy  = 1'b1;
        for (int c = 0; c < 5; c++) tick();
        chk("stall estado", {28'd0, estado}, {28'd0, S_MEM});
        tick();
        chk("stall hold estado", {28'd0, estado}, {28'd0, S_MEM});
        chk("stall en_mem", {31'd0, en_mem}, 32'd1);
        do_reset();
        mem_busy = 1'b0;
        chk("rst in stall estado", {28'd0, estado}, {28'd0, S_IF});
        chk("rst in stall cycle_count", cyc, 32'd0);
        chk("rst in stall instr_count", ins, 32'd0);
        chk("rst in stall final", {31'd0, fin}, 32'd0);

        // With no settle waits, EX goes straight to MEM and WB goes
        // straight to PCUP, giving 6 cycles per instruction.
        zst = '{S_IF, S_ID, S_EX, S_MEM, S_WB, S_PCUP, S_IF, S_ID};
        z_rst = 1'b1;
        tick();
        z_rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            chk($sformatf("nowait c%0d estado", c + 1), {28'd0, z_estado}, {28'd0, zst[c]});
            chk($sformatf("nowait c%0d en_pc", c + 1), {31'd0, z_en_pc}, {31'd0, (zst[c] == S_PCUP)});
            tick();
        end
        chk("nowait cycle_count", z_cyc, 32'd8);
        chk("nowait instr_count", z_ins, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
